inst_cache_way1: RTL

INST_CACHE_WAY1 -- requirements
Module: inst_cache_way1

---
 rtl/inst_cache_way1.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/inst_cache_way1.sv
// Direct-mapped instruction cache: 16 lines of one 32-bit word each.
// Lines are filled from a single-word backing memory on a miss.
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   request_i    fetch request, held with instAddr_i until dataOk_o
//   instAddr_i   fetch byte address (bits [1:0] ignored)
//   jumpFlag_i   redirect; abandons any outstanding fetch
//   fence_i      invalidate all lines (acted on only while idle)
//   dataOk_o     one-cycle pulse, inst_o valid
//   inst_o       fetched instruction, holds its value between pulses
//   mem_req_o    refill read request
//   mem_addr_o   refill word address
//   mem_ack_i    refill data valid (single cycle)
//   mem_data_i   refill data
module inst_cache_way1 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        request_i,
  input  logic [31:0] instAddr_i,
  input  logic        jumpFlag_i,
  input  logic        fence_i,
  output logic        dataOk_o,
  output logic [31:0] inst_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {StIdle, StRefill, StResp, StDrop} state_e;

  state_e      state_q, state_d;
  logic [15:0] valid_q, valid_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] inst_q, inst_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] refill_data_q, refill_data_d;

  logic [25:0] tag_q  [16];
  logic [31:0] data_q [16];

  logic [3:0]  lookup_idx;
  logic [25:0] lookup_tag;
  logic        lookup_hit;
  logic [3:0]  wr_idx;
  logic        line_we;

  // Byte-offset bits of the fetch address carry no information for a word cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^instAddr_i[1:0];

  assign lookup_idx = instAddr_i[5:2];
  assign lookup_tag = instAddr_i[31:6];
  assign lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

  // The refill target is always the latched miss address.
  assign wr_idx = mem_addr_q[5:2];

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    data_ok_d     = 1'b0;
    inst_d        = inst_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    refill_data_d = refill_data_q;
    line_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fence_i) begin
          // Fence wins over any lookup in the same cycle.
          valid_d = '0;
        end else if (request_i && !jumpFlag_i) begin
          if (lookup_hit) begin
            data_ok_d = 1'b1;
            inst_d    = data_q[lookup_idx];
          end else begin
            state_d    = StRefill;
            mem_req_d  = 1'b1;
            mem_addr_d = {instAddr_i[31:2], 2'b00};
          end
        end
      end

      StRefill: begin
        if (mem_ack_i) begin
          line_we       = 1'b1;
          mem_req_d     = 1'b0;
          refill_data_d = mem_data_i;
          state_d       = jumpFlag_i ? StIdle : StResp;
        end else if (jumpFlag_i) begin
          state_d = StDrop;
        end
      end

      StDrop: begin
        // Abandoned fetch: finish the memory handshake and keep the line.
        if (mem_ack_i) begin
          line_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end

      StResp: begin
        state_d = StIdle;
        if (!jumpFlag_i) begin
          data_ok_d = 1'b1;
          inst_d    = refill_data_q;
        end
      end

      default: state_d = StIdle;
    endcase

    if (line_we) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      valid_q       <= '0;
      data_ok_q     <= 1'b0;
      inst_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      refill_data_q <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      data_ok_q     <= data_ok_d;
      inst_q        <= inst_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      refill_data_q <= refill_data_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (reset_n && line_we) begin
      tag_q[wr_idx]  <= mem_addr_q[31:6];
      data_q[wr_idx] <= mem_data_i;
    end
  end

  assign dataOk_o   = data_ok_q;
  assign inst_o     = inst_q;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

endmodule
